ysyx_041514_csr_ctrl: RTL and testbench

Multi-cycle sequencer that owns the single read/write port pair of the CSR register file. It performs a fixed-latency read-modify-write for Zicsr instructions issued by execute, using the `ysyx_041514_CSROP_*` encodings. It arbitrates that port against single-cycle trap-unit writes (mepc/mcause/mstatus updates) and returns the old CSR value to writeback through a valid/ready handshake.

---
 rtl/ysyx_041514_csr_ctrl.sv | 185 ++++++++++++++++++
 tb/tb_ysyx_041514_csr_ctrl.sv | 401 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ysyx_041514_csr_ctrl.sv
// CSR port sequencer: runs Zicsr read-modify-write sequences against the CSR file
// and lets single-cycle trap-unit writes use the same port while it is idle.

`ifndef ysyx_041514_XLEN
`define ysyx_041514_XLEN 64
`endif
`ifndef ysyx_041514_IMM_LEN
`define ysyx_041514_IMM_LEN 5
`endif
`ifndef ysyx_041514_CSROP_LEN
`define ysyx_041514_CSROP_LEN 3
`endif
`ifndef ysyx_041514_CSROP_NONE
`define ysyx_041514_CSROP_NONE 3'd0
`endif
`ifndef ysyx_041514_CSROP_READ
`define ysyx_041514_CSROP_READ 3'd1
`endif
`ifndef ysyx_041514_CSROP_WRITE
`define ysyx_041514_CSROP_WRITE 3'd2
`endif
`ifndef ysyx_041514_CSROP_SET
`define ysyx_041514_CSROP_SET 3'd3
`endif
`ifndef ysyx_041514_CSROP_CLEAR
`define ysyx_041514_CSROP_CLEAR 3'd4
`endif

module ysyx_041514_csr_ctrl (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               req_valid_i,
  output logic                               req_ready_o,
  input  logic [11:0]                        req_addr_i,
  input  logic [`ysyx_041514_CSROP_LEN-1:0]  req_op_i,
  input  logic [`ysyx_041514_IMM_LEN-1:0]    req_imm_i,
  input  logic                               req_imm_valid_i,
  input  logic [`ysyx_041514_XLEN-1:0]       req_rs1_data_i,
  input  logic                               trap_valid_i,
  output logic                               trap_ready_o,
  input  logic [11:0]                        trap_addr_i,
  input  logic [`ysyx_041514_XLEN-1:0]       trap_wdata_i,
  input  logic                               flush_i,
  output logic                               csr_ren_o,
  output logic [11:0]                        csr_raddr_o,
  input  logic [`ysyx_041514_XLEN-1:0]       csr_rdata_i,
  output logic                               csr_wen_o,
  output logic [11:0]                        csr_waddr_o,
  output logic [`ysyx_041514_XLEN-1:0]       csr_wdata_o,
  output logic                               resp_valid_o,
  input  logic                               resp_ready_i,
  output logic [`ysyx_041514_XLEN-1:0]       resp_rd_data_o,
  output logic                               resp_illegal_o
);

  localparam int XLEN = `ysyx_041514_XLEN;
  localparam int OPW  = `ysyx_041514_CSROP_LEN;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD,
    S_EX,
    S_WR,
    S_RSP
  } state_e;

  state_e            r_state;
  state_e            w_next;
  logic [11:0]       r_addr;
  logic [OPW-1:0]    r_op;
  logic [XLEN-1:0]   r_op2;
  logic [XLEN-1:0]   r_old;
  logic [XLEN-1:0]   r_wdata;
  logic              r_wneed;
  logic              r_illegal;

  logic              w_idle;
  logic              w_accept;
  logic              w_trap_fire;
  logic              w_inst_wen;
  logic [XLEN-1:0]   w_op2;
  logic [XLEN-1:0]   w_new;
  logic              w_wants_write;
  logic              w_illegal;

  // Trap writes own the port whenever the sequencer is idle, so they can never
  // collide with an instruction write, which only happens in WR.
  assign w_idle       = (r_state == S_IDLE);
  assign w_trap_fire  = w_idle && trap_valid_i;
  assign trap_ready_o = w_trap_fire;
  assign req_ready_o  = w_idle && !trap_valid_i && !flush_i;
  assign w_accept     = req_valid_i && req_ready_o;
  assign w_op2        = req_imm_valid_i ? XLEN'(req_imm_i) : req_rs1_data_i;

  always_comb begin
    w_new         = csr_rdata_i;
    w_wants_write = 1'b0;
    case (r_op)
      `ysyx_041514_CSROP_WRITE: begin
        w_new         = r_op2;
        w_wants_write = 1'b1;
      end
      `ysyx_041514_CSROP_SET: begin
        w_new         = csr_rdata_i | r_op2;
        w_wants_write = |r_op2;
      end
      `ysyx_041514_CSROP_CLEAR: begin
        w_new         = csr_rdata_i & ~r_op2;
        w_wants_write = |r_op2;
      end
      default: begin
        w_new         = csr_rdata_i;
        w_wants_write = 1'b0;
      end
    endcase
  end

  // Address space 0xC00-0xFFF is read-only; only an actual write attempt is illegal.
  assign w_illegal = w_wants_write && (r_addr[11:10] == 2'b11);

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_next = (req_op_i == `ysyx_041514_CSROP_NONE) ? S_RSP : S_RD;
        end
      end
      S_RD:    w_next = flush_i ? S_IDLE : S_EX;
      S_EX:    w_next = flush_i ? S_IDLE : S_WR;
      S_WR:    w_next = flush_i ? S_IDLE : S_RSP;
      S_RSP: begin
        if (flush_i || resp_ready_i) begin
          w_next = S_IDLE;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_addr    <= '0;
      r_op      <= '0;
      r_op2     <= '0;
      r_old     <= '0;
      r_wdata   <= '0;
      r_wneed   <= 1'b0;
      r_illegal <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_addr    <= req_addr_i;
        r_op      <= req_op_i;
        r_op2     <= w_op2;
        r_old     <= '0;
        r_wdata   <= '0;
        r_wneed   <= 1'b0;
        r_illegal <= 1'b0;
      end
      if (r_state == S_EX) begin
        r_old     <= csr_rdata_i;
        r_wdata   <= w_new;
        r_wneed   <= w_wants_write && !w_illegal;
        r_illegal <= w_illegal;
      end
    end
  end

  // A reset arriving in WR still suppresses the instruction write.
  assign w_inst_wen = (r_state == S_WR) && r_wneed && !rst;

  assign csr_ren_o   = (r_state == S_RD);
  assign csr_raddr_o = csr_ren_o ? r_addr : 12'h000;

  assign csr_wen_o   = w_trap_fire || w_inst_wen;
  assign csr_waddr_o = w_trap_fire ? trap_addr_i  : (w_inst_wen ? r_addr  : 12'h000);
  assign csr_wdata_o = w_trap_fire ? trap_wdata_i : (w_inst_wen ? r_wdata : '0);

  assign resp_valid_o   = (r_state == S_RSP);
  assign resp_rd_data_o = resp_valid_o ? r_old : '0;
  assign resp_illegal_o = resp_valid_o && r_illegal;

endmodule

// File: tb/tb_ysyx_041514_csr_ctrl.sv
// Self-checking bench for ysyx_041514_csr_ctrl: directed table, random transactions
// against a behavioural CSR model, and hand-written trap/flush/reset sequences.

`ifndef ysyx_041514_XLEN
`define ysyx_041514_XLEN 64
`endif
`ifndef ysyx_041514_IMM_LEN
`define ysyx_041514_IMM_LEN 5
`endif
`ifndef ysyx_041514_CSROP_LEN
`define ysyx_041514_CSROP_LEN 3
`endif
`ifndef ysyx_041514_CSROP_NONE
`define ysyx_041514_CSROP_NONE 3'd0
`endif
`ifndef ysyx_041514_CSROP_READ
`define ysyx_041514_CSROP_READ 3'd1
`endif
`ifndef ysyx_041514_CSROP_WRITE
`define ysyx_041514_CSROP_WRITE 3'd2
`endif
`ifndef ysyx_041514_CSROP_SET
`define ysyx_041514_CSROP_SET 3'd3
`endif
`ifndef ysyx_041514_CSROP_CLEAR
`define ysyx_041514_CSROP_CLEAR 3'd4
`endif

module tb_ysyx_041514_csr_ctrl;

  localparam int XLEN = `ysyx_041514_XLEN;
  localparam int IMML = `ysyx_041514_IMM_LEN;
  localparam int OPL  = `ysyx_041514_CSROP_LEN;

  logic            clk = 1'b0;
  logic            rst;
  logic            req_valid_i;
  logic            req_ready_o;
  logic [11:0]     req_addr_i;
  logic [OPL-1:0]  req_op_i;
  logic [IMML-1:0] req_imm_i;
  logic            req_imm_valid_i;
  logic [XLEN-1:0] req_rs1_data_i;
  logic            trap_valid_i;
  logic            trap_ready_o;
  logic [11:0]     trap_addr_i;
  logic [XLEN-1:0] trap_wdata_i;
  logic            flush_i;
  logic            csr_ren_o;
  logic [11:0]     csr_raddr_o;
  logic [XLEN-1:0] csr_rdata_i;
  logic            csr_wen_o;
  logic [11:0]     csr_waddr_o;
  logic [XLEN-1:0] csr_wdata_o;
  logic            resp_valid_o;
  logic            resp_ready_i;
  logic [XLEN-1:0] resp_rd_data_o;
  logic            resp_illegal_o;

  logic [XLEN-1:0] csrMem [0:4095];
  int vecCount  = 0;
  int missCount = 0;

  typedef struct {
    logic [OPL-1:0]  op;
    logic [11:0]     addr;
    logic            immV;
    logic [IMML-1:0] imm;
    logic [XLEN-1:0] rs1;
    logic [XLEN-1:0] init;
    logic [XLEN-1:0] expRd;
    logic            expWen;
    logic [XLEN-1:0] expWdata;
    logic            expIll;
    int              hold;
  } vec_t;

  ysyx_041514_csr_ctrl dut (
    .clk             (clk),
    .rst             (rst),
    .req_valid_i     (req_valid_i),
    .req_ready_o     (req_ready_o),
    .req_addr_i      (req_addr_i),
    .req_op_i        (req_op_i),
    .req_imm_i       (req_imm_i),
    .req_imm_valid_i (req_imm_valid_i),
    .req_rs1_data_i  (req_rs1_data_i),
    .trap_valid_i    (trap_valid_i),
    .trap_ready_o    (trap_ready_o),
    .trap_addr_i     (trap_addr_i),
    .trap_wdata_i    (trap_wdata_i),
    .flush_i         (flush_i),
    .csr_ren_o       (csr_ren_o),
    .csr_raddr_o     (csr_raddr_o),
    .csr_rdata_i     (csr_rdata_i),
    .csr_wen_o       (csr_wen_o),
    .csr_waddr_o     (csr_waddr_o),
    .csr_wdata_o     (csr_wdata_o),
    .resp_valid_o    (resp_valid_o),
    .resp_ready_i    (resp_ready_i),
    .resp_rd_data_o  (resp_rd_data_o),
    .resp_illegal_o  (resp_illegal_o)
  );

  always #5 clk = ~clk;

  // CSR register file: registered read data, write on the clock edge.
  always @(posedge clk) begin
    if (csr_ren_o) csr_rdata_i <= csrMem[csr_raddr_o];
    if (csr_wen_o) csrMem[csr_waddr_o] <= csr_wdata_o;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    vecCount++;
    if (act !== exp) begin
      missCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic [OPL-1:0] op, input logic [11:0] addr,
                               input logic immV, input logic [IMML-1:0] imm,
                               input logic [XLEN-1:0] rs1);
    req_valid_i     = 1'b1;
    req_op_i        = op;
    req_addr_i      = addr;
    req_imm_valid_i = immV;
    req_imm_i       = imm;
    req_rs1_data_i  = rs1;
  endtask

  // Loads a CSR through the trap write port; must be called while idle.
  task automatic setCsr(input logic [11:0] addr, input logic [XLEN-1:0] val);
    trap_valid_i = 1'b1;
    trap_addr_i  = addr;
    trap_wdata_i = val;
    #1;
    tick();
    trap_valid_i = 1'b0;
  endtask

  // Reference behaviour from the Zicsr rules; addresses 0xC00 and up are read-only.
  function automatic void refCsr(input logic [OPL-1:0] op, input logic [11:0] addr,
                                 input logic [XLEN-1:0] op2, input logic [XLEN-1:0] old,
                                 output logic [XLEN-1:0] rd, output logic wen,
                                 output logic [XLEN-1:0] wdata, output logic ill);
    logic wants;
    logic [XLEN-1:0] nv;
    wants = 1'b0;
    nv    = old;
    rd    = old;
    if (op == `ysyx_041514_CSROP_NONE) rd = 0;
    else if (op == `ysyx_041514_CSROP_WRITE) begin nv = op2; wants = 1'b1; end
    else if (op == `ysyx_041514_CSROP_SET) begin nv = old | op2; wants = (op2 != 0); end
    else if (op == `ysyx_041514_CSROP_CLEAR) begin nv = old & ~op2; wants = (op2 != 0); end
    ill   = wants && (addr >= 12'hC00);
    wen   = wants && (addr < 12'hC00);
    wdata = nv;
  endfunction

  task automatic runTxn(input vec_t v);
    int budget;
    resp_ready_i = (v.hold == 0);
    applyStimulus(v.op, v.addr, v.immV, v.imm, v.rs1);
    #1;
    budget = 0;
    while (!req_ready_o && budget < 20) begin
      tick();
      budget++;
    end
    checkOutput("req_ready", req_ready_o, 1);
    tick();
    req_valid_i = 1'b0;
    #1;
    if (v.op == `ysyx_041514_CSROP_NONE) begin
      checkOutput("none_ren", csr_ren_o, 0);
      budget = 0;
      while (!resp_valid_o && budget < 2) begin
        checkOutput("none_wen", csr_wen_o, 0);
        tick();
        budget++;
      end
    end else begin
      checkOutput("rd_ren", csr_ren_o, 1);
      checkOutput("rd_raddr", csr_raddr_o, v.addr);
      checkOutput("rd_wen", csr_wen_o, 0);
      tick();
      checkOutput("ex_ren", csr_ren_o, 0);
      checkOutput("ex_wen", csr_wen_o, 0);
      tick();
      checkOutput("wr_wen", csr_wen_o, v.expWen);
      if (v.expWen) begin
        checkOutput("wr_waddr", csr_waddr_o, v.addr);
        checkOutput("wr_wdata", csr_wdata_o, v.expWdata);
      end
      checkOutput("wr_valid", resp_valid_o, 0);
      tick();
    end
    checkOutput("resp_valid", resp_valid_o, 1);
    checkOutput("resp_rd_data", resp_rd_data_o, v.expRd);
    checkOutput("resp_illegal", resp_illegal_o, v.expIll);
    checkOutput("rsp_wen", csr_wen_o, 0);
    if (v.hold > 0) begin
      trap_valid_i = 1'b1;
      trap_addr_i  = 12'h7C0;
      trap_wdata_i = 64'h5A;
      #1;
      for (int i = 0; i < v.hold; i++) begin
        checkOutput("hold_trap_ready", trap_ready_o, 0);
        checkOutput("hold_rd_data", resp_rd_data_o, v.expRd);
        checkOutput("hold_valid", resp_valid_o, 1);
        tick();
      end
      resp_ready_i = 1'b1;
      #1;
      checkOutput("hold_end_valid", resp_valid_o, 1);
      tick();
      checkOutput("post_trap_ready", trap_ready_o, 1);
      checkOutput("post_trap_wen", csr_wen_o, 1);
      trap_valid_i = 1'b0;
      tick();
    end else begin
      tick();
    end
    checkOutput("idle_ready", req_ready_o, 1);
    checkOutput("csr_value", csrMem[v.addr], v.expWen ? v.expWdata : v.init);
  endtask

  initial begin
    #400000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    vec_t vecs[$];
    vec_t v;
    logic [11:0] addrPool [0:5];

    addrPool[0] = 12'h300; addrPool[1] = 12'h341; addrPool[2] = 12'h305;
    addrPool[3] = 12'hC00; addrPool[4] = 12'hC01; addrPool[5] = 12'h340;

    //               op                        addr    immV imm    rs1                     init                    expRd                   wen  wdata                   ill  hold
    vecs.push_back('{`ysyx_041514_CSROP_SET,   12'h300, 1'b0, 5'd0, 64'h80,                 64'h8,                  64'h8,                  1'b1, 64'h88,                 1'b0, 0});
    vecs.push_back('{`ysyx_041514_CSROP_CLEAR, 12'h300, 1'b1, 5'd0, 64'hFF,                 64'h88,                 64'h88,                 1'b0, 64'h0,                  1'b0, 0});
    vecs.push_back('{`ysyx_041514_CSROP_WRITE, 12'hC00, 1'b0, 5'd0, 64'h1,                  64'h1234,               64'h1234,               1'b0, 64'h0,                  1'b1, 0});
    vecs.push_back('{`ysyx_041514_CSROP_READ,  12'hC00, 1'b0, 5'd0, 64'h1,                  64'h1234,               64'h1234,               1'b0, 64'h0,                  1'b0, 0});
    vecs.push_back('{`ysyx_041514_CSROP_CLEAR, 12'h300, 1'b1, 5'd8, 64'h0,                  64'h88,                 64'h88,                 1'b1, 64'h80,                 1'b0, 0});
    vecs.push_back('{`ysyx_041514_CSROP_WRITE, 12'h341, 1'b1, 5'd5, 64'hDEAD,               64'hFFFFFFFFFFFFFFFF,   64'hFFFFFFFFFFFFFFFF,   1'b1, 64'h5,                  1'b0, 3});
    vecs.push_back('{`ysyx_041514_CSROP_NONE,  12'h300, 1'b0, 5'd0, 64'h7,                  64'h42,                 64'h0,                  1'b0, 64'h0,                  1'b0, 0});
    vecs.push_back('{`ysyx_041514_CSROP_SET,   12'hC01, 1'b0, 5'd0, 64'h0,                  64'h77,                 64'h77,                 1'b0, 64'h0,                  1'b0, 0});
    vecs.push_back('{`ysyx_041514_CSROP_SET,   12'hC01, 1'b0, 5'd0, 64'h1,                  64'h77,                 64'h77,                 1'b0, 64'h0,                  1'b1, 1});
    vecs.push_back('{`ysyx_041514_CSROP_SET,   12'h300, 1'b0, 5'd0, 64'hF000000000000000,   64'h8,                  64'h8,                  1'b1, 64'hF000000000000008,   1'b1 & 1'b0, 0});

    rst = 1'b1; req_valid_i = 1'b0; req_op_i = '0; req_addr_i = '0; req_imm_i = '0;
    req_imm_valid_i = 1'b0; req_rs1_data_i = '0; trap_valid_i = 1'b0; trap_addr_i = '0;
    trap_wdata_i = '0; flush_i = 1'b0; resp_ready_i = 1'b1; csr_rdata_i = '0;
    tick(); tick(); tick();
    rst = 1'b0;
    #1;
    checkOutput("reset_req_ready", req_ready_o, 1);
    checkOutput("reset_trap_ready", trap_ready_o, 0);
    checkOutput("reset_ren", csr_ren_o, 0);
    checkOutput("reset_wen", csr_wen_o, 0);
    checkOutput("reset_raddr", csr_raddr_o, 0);
    checkOutput("reset_waddr", csr_waddr_o, 0);
    checkOutput("reset_resp_valid", resp_valid_o, 0);
    checkOutput("reset_rd_data", resp_rd_data_o, 0);
    checkOutput("reset_illegal", resp_illegal_o, 0);

    $display("[TB] directed table");
    foreach (vecs[i]) begin
      setCsr(vecs[i].addr, vecs[i].init);
      runTxn(vecs[i]);
    end

    $display("[TB] trap and request in the same cycle");
    setCsr(12'h300, 64'h8);
    applyStimulus(`ysyx_041514_CSROP_SET, 12'h300, 1'b0, 5'd0, 64'h80);
    trap_valid_i = 1'b1; trap_addr_i = 12'h341; trap_wdata_i = 64'h80000004;
    #1;
    checkOutput("trap_wen", csr_wen_o, 1);
    checkOutput("trap_waddr", csr_waddr_o, 12'h341);
    checkOutput("trap_wdata", csr_wdata_o, 64'h80000004);
    checkOutput("trap_req_ready", req_ready_o, 0);
    checkOutput("trap_ready", trap_ready_o, 1);
    tick();
    trap_valid_i = 1'b0;
    v = '{`ysyx_041514_CSROP_SET, 12'h300, 1'b0, 5'd0, 64'h80, 64'h8, 64'h8, 1'b1, 64'h88, 1'b0, 0};
    runTxn(v);
    checkOutput("trap_mem", csrMem[12'h341], 64'h80000004);

    $display("[TB] flush in IDLE");
    applyStimulus(`ysyx_041514_CSROP_READ, 12'h300, 1'b0, 5'd0, 64'h0);
    flush_i = 1'b1; trap_valid_i = 1'b1; trap_addr_i = 12'h340; trap_wdata_i = 64'h33;
    #1;
    checkOutput("flush_idle_req_ready", req_ready_o, 0);
    checkOutput("flush_idle_trap_ready", trap_ready_o, 1);
    tick();
    flush_i = 1'b0; trap_valid_i = 1'b0; req_valid_i = 1'b0;
    #1;
    checkOutput("flush_idle_mem", csrMem[12'h340], 64'h33);
    checkOutput("flush_idle_no_ren", csr_ren_o, 0);

    $display("[TB] flush in EX");
    setCsr(12'h305, 64'h10);
    applyStimulus(`ysyx_041514_CSROP_WRITE, 12'h305, 1'b0, 5'd0, 64'h99);
    #1;
    tick();
    req_valid_i = 1'b0;
    tick();
    flush_i = 1'b1;
    #1;
    checkOutput("flush_ex_wen", csr_wen_o, 0);
    tick();
    flush_i = 1'b0;
    #1;
    checkOutput("flush_ex_wen2", csr_wen_o, 0);
    checkOutput("flush_ex_valid", resp_valid_o, 0);
    checkOutput("flush_ex_idle", req_ready_o, 1);
    tick();
    checkOutput("flush_ex_valid2", resp_valid_o, 0);
    checkOutput("flush_ex_mem", csrMem[12'h305], 64'h10);

    $display("[TB] flush in WR");
    applyStimulus(`ysyx_041514_CSROP_WRITE, 12'h305, 1'b0, 5'd0, 64'h99);
    #1;
    tick();
    req_valid_i = 1'b0;
    tick();
    tick();
    flush_i = 1'b1;
    #1;
    checkOutput("flush_wr_wen", csr_wen_o, 1);
    checkOutput("flush_wr_wdata", csr_wdata_o, 64'h99);
    tick();
    flush_i = 1'b0;
    #1;
    checkOutput("flush_wr_valid", resp_valid_o, 0);
    checkOutput("flush_wr_idle", req_ready_o, 1);
    checkOutput("flush_wr_mem", csrMem[12'h305], 64'h99);

    $display("[TB] flush in RSP");
    resp_ready_i = 1'b0;
    applyStimulus(`ysyx_041514_CSROP_READ, 12'h305, 1'b0, 5'd0, 64'h0);
    #1;
    tick();
    req_valid_i = 1'b0;
    tick(); tick(); tick();
    checkOutput("flush_rsp_valid", resp_valid_o, 1);
    checkOutput("flush_rsp_rd_data", resp_rd_data_o, 64'h99);
    flush_i = 1'b1;
    tick();
    flush_i = 1'b0;
    resp_ready_i = 1'b1;
    #1;
    checkOutput("flush_rsp_dropped", resp_valid_o, 0);
    checkOutput("flush_rsp_idle", req_ready_o, 1);

    $display("[TB] reset in EX");
    applyStimulus(`ysyx_041514_CSROP_WRITE, 12'h305, 1'b0, 5'd0, 64'h77);
    #1;
    tick();
    req_valid_i = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    checkOutput("rst_ex_wen", csr_wen_o, 0);
    checkOutput("rst_ex_valid", resp_valid_o, 0);
    checkOutput("rst_ex_idle", req_ready_o, 1);
    tick();
    checkOutput("rst_ex_mem", csrMem[12'h305], 64'h99);

    $display("[TB] random transactions");
    for (int n = 0; n < 60; n++) begin
      logic [XLEN-1:0] op2;
      v.op   = OPL'($urandom_range(0, 4));
      v.addr = addrPool[$urandom_range(0, 5)];
      v.immV = 1'($urandom_range(0, 1));
      v.imm  = ($urandom_range(0, 3) == 0) ? '0 : IMML'($urandom);
      v.rs1  = ($urandom_range(0, 3) == 0) ? '0 : {$urandom, $urandom};
      v.init = {$urandom, $urandom};
      v.hold = $urandom_range(0, 2);
      op2    = v.immV ? XLEN'(v.imm) : v.rs1;
      refCsr(v.op, v.addr, op2, v.init, v.expRd, v.expWen, v.expWdata, v.expIll);
      setCsr(v.addr, v.init);
      runTxn(v);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
    $finish;
  end

endmodule
